// File: rtl/mgmt_pkg.sv
// mgmt_pkg: shared definitions for the management-bus hub.
//   - Bus widths (MGMT_AW, MGMT_DW).
//   - err_code encodings reported on the hub's err_code output.
//   - Hub FSM state encoding.
//   - Default read-data pattern returned on a bus fault.
//   - Helper that sizes the timeout counter.
package mgmt_pkg;

    localparam int MGMT_AW = 32;
    localparam int MGMT_DW = 32;

    localparam logic [MGMT_DW-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ACK_TMO = 2'd1,
        ERR_RXE_TMO = 2'd2,
        ERR_COLL    = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_WAIT_RXE = 2'd2,
        ST_ERR_RD   = 2'd3
    } state_e;

    // One spare bit above the largest timeout so the counter can saturate
    // past the terminal value without ever wrapping back to a small count.
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/mgmt_hub_sel.sv
// mgmt_hub_sel: response selector over NSLV slave ports.
//   vld_i   [NSLV]          per-slave valid bits (ack or rxe)
//   dat_i   [NSLV*MGMT_DW]  per-slave data, slave i at [32i+31:32i]
//   any_o                   at least one valid bit set
//   multi_o                 more than one valid bit set (collision)
//   sel_o   [MGMT_DW]       data of the valid slave (OR of all valid
//                           slaves; only meaningful when not multi_o)
module mgmt_hub_sel
    import mgmt_pkg::*;
#(
    parameter int NSLV = 5
) (
    input  logic [NSLV-1:0]         vld_i,
    input  logic [NSLV*MGMT_DW-1:0] dat_i,
    output logic                    any_o,
    output logic                    multi_o,
    output logic [MGMT_DW-1:0]      sel_o
);

    assign any_o = |vld_i;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_o = (vld_i & (vld_i - NSLV'(1))) != '0;

    always_comb begin
        sel_o = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (vld_i[i]) begin
                sel_o = sel_o | dat_i[i*MGMT_DW +: MGMT_DW];
            end
        end
    end

endmodule

// File: rtl/mgmt_hub.sv
// mgmt_hub: hub between the core's mgmt master port and NSLV mgmt slaves.
// Merges slave ack/rxe/rxd into one response, tracks the outstanding
// transaction with a small FSM, and completes faulting transactions
// itself (ack timeout, rxe timeout, multi-slave collision) so the core
// never hangs.
//
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   mgmt_req/adr/rwn    core request (req held until ack), address, 1=read
//   mgmt_ack            acknowledge to core (combinational in WAIT_ACK)
//   mgmt_rxe/rxd        registered read-data valid / data to core
//   s_ack/s_rxe/s_rxd   per-slave ack, read valid, read data
//   bus_err, err_code   one-cycle fault pulse and fault type
//
// Optional build macro MGMT_HUB_STAT_EN adds:
//   err_cnt [16]        saturating count of bus_err pulses
//   err_adr [32]        address of the most recent faulting transaction
module mgmt_hub
    import mgmt_pkg::*;
#(
    parameter int                 NSLV     = 5,
    parameter int                 ACK_TMO  = 64,
    parameter int                 RXE_TMO  = 256,
    parameter logic [MGMT_DW-1:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    mgmt_req,
    input  logic [MGMT_AW-1:0]      mgmt_adr,
    input  logic                    mgmt_rwn,
    output logic                    mgmt_ack,
    output logic                    mgmt_rxe,
    output logic [MGMT_DW-1:0]      mgmt_rxd,
    input  logic [NSLV-1:0]         s_ack,
    input  logic [NSLV-1:0]         s_rxe,
    input  logic [NSLV*MGMT_DW-1:0] s_rxd,
    output logic                    bus_err,
    output logic [1:0]              err_code
`ifdef MGMT_HUB_STAT_EN
    ,
    output logic [15:0]             err_cnt,
    output logic [MGMT_AW-1:0]      err_adr
`endif
);

    localparam int CNT_W = cnt_width(ACK_TMO, RXE_TMO);

    state_e             state_q;
    logic               rwn_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               hold_q;     // first IDLE cycle after a transaction
    logic               rxe_q;
    logic [MGMT_DW-1:0] rxd_q;
    logic               rerr_q;     // fault found in the read-data phase
    err_code_e          rcode_q;

    logic               ack_any, ack_multi, ack_tmo, ack_fault;
    logic               rxe_any, rxe_multi, rxe_tmo, rxe_fault;
    logic [MGMT_DW-1:0] rxe_dat;
    err_code_e          ack_code;
    logic               in_wack, in_wrxe;

    // Ack only needs the one-hot check; the data lanes are unused.
    mgmt_hub_sel #(.NSLV(NSLV)) u_sel_ack (
        .vld_i   (s_ack),
        .dat_i   ('0),
        .any_o   (ack_any),
        .multi_o (ack_multi),
        .sel_o   ()
    );

    mgmt_hub_sel #(.NSLV(NSLV)) u_sel_rxe (
        .vld_i   (s_rxe),
        .dat_i   (s_rxd),
        .any_o   (rxe_any),
        .multi_o (rxe_multi),
        .sel_o   (rxe_dat)
    );

    assign in_wack = (state_q == ST_WAIT_ACK);
    assign in_wrxe = (state_q == ST_WAIT_RXE);

    assign ack_tmo   = in_wack && !ack_any && (cnt_q >= CNT_W'(ACK_TMO - 1));
    assign ack_fault = in_wack && (ack_multi || ack_tmo);
    assign ack_code  = ack_multi ? ERR_COLL : ERR_ACK_TMO;

    assign rxe_tmo   = in_wrxe && !rxe_any && (cnt_q >= CNT_W'(RXE_TMO - 1));
    assign rxe_fault = in_wrxe && (rxe_multi || rxe_tmo);

    // Ack-phase faults are reported in the ack cycle itself; read-phase
    // faults ride along with the registered rxe one cycle later. The two
    // can never coincide because a registered read response always lands
    // in IDLE or ERR_RD.
    assign mgmt_ack = in_wack && (ack_any || ack_tmo);
    assign bus_err  = ack_fault || rerr_q;
    assign err_code = ack_fault ? ack_code : rcode_q;
    assign mgmt_rxe = rxe_q;
    assign mgmt_rxd = rxd_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            rwn_q   <= 1'b0;
            cnt_q   <= '0;
            hold_q  <= 1'b0;
            rxe_q   <= 1'b0;
            rxd_q   <= '0;
            rerr_q  <= 1'b0;
            rcode_q <= ERR_NONE;
        end else begin
            rxe_q   <= 1'b0;
            rerr_q  <= 1'b0;
            rcode_q <= ERR_NONE;
            hold_q  <= 1'b0;
            if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (mgmt_req && !hold_q) begin
                        rwn_q   <= mgmt_rwn;
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_ACK;
                    end
                end

                ST_WAIT_ACK: begin
                    if (ack_any || ack_tmo) begin
                        if (!rwn_q) begin
                            state_q <= ST_IDLE;
                            hold_q  <= 1'b1;
                        end else if (ack_fault) begin
                            // Error data leaves on the cycle right after the ack.
                            state_q <= ST_ERR_RD;
                            rxe_q   <= 1'b1;
                            rxd_q   <= ERR_DATA;
                        end else begin
                            state_q <= ST_WAIT_RXE;
                            cnt_q   <= '0;
                        end
                    end
                end

                ST_WAIT_RXE: begin
                    if (rxe_any || rxe_tmo) begin
                        state_q <= ST_IDLE;
                        hold_q  <= 1'b1;
                        rxe_q   <= 1'b1;
                        rxd_q   <= rxe_fault ? ERR_DATA : rxe_dat;
                        if (rxe_fault) begin
                            rerr_q  <= 1'b1;
                            rcode_q <= rxe_multi ? ERR_COLL : ERR_RXE_TMO;
                        end
                    end
                end

                ST_ERR_RD: begin
                    state_q <= ST_IDLE;
                    hold_q  <= 1'b1;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MGMT_HUB_STAT_EN
    logic [MGMT_AW-1:0] adr_q;
    logic [15:0]        err_cnt_q;
    logic [MGMT_AW-1:0] err_adr_q;

    // adr_q is stable whenever bus_err fires: the hold cycle blocks a new
    // capture during a registered read-phase fault.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            adr_q     <= '0;
            err_cnt_q <= '0;
            err_adr_q <= '0;
        end else begin
            if (state_q == ST_IDLE && mgmt_req && !hold_q) begin
                adr_q <= mgmt_adr;
            end
            if (bus_err) begin
                if (err_cnt_q != '1) begin
                    err_cnt_q <= err_cnt_q + 16'd1;
                end
                err_adr_q <= adr_q;
            end
        end
    end

    assign err_cnt = err_cnt_q;
    assign err_adr = err_adr_q;
`else
    logic adr_unused;
    assign adr_unused = ^mgmt_adr;
`endif

endmodule

// File: tb/tb_mgmt_hub.sv
`timescale 1ns/1ps
module tb_mgmt_hub;

    localparam int NSLV = 5;

    logic                 clk      = 1'b0;
    logic                 rstn     = 1'b0;
    logic                 mgmt_req = 1'b0;
    logic [31:0]          mgmt_adr = '0;
    logic                 mgmt_rwn = 1'b0;
    logic                 mgmt_ack;
    logic                 mgmt_rxe;
    logic [31:0]          mgmt_rxd;
    logic [NSLV-1:0]      s_ack    = '0;
    logic [NSLV-1:0]      s_rxe    = '0;
    logic [NSLV*32-1:0]   s_rxd    = '0;
    logic                 bus_err;
    logic [1:0]           err_code;
`ifdef MGMT_HUB_STAT_EN
    logic [15:0]          err_cnt;
    logic [31:0]          err_adr;
`endif

    int n_chk = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] rxd;
        logic        err;
        logic [1:0]  code;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    mgmt_hub #(
        .NSLV     (NSLV),
        .ACK_TMO  (64),
        .RXE_TMO  (256),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .mgmt_req (mgmt_req),
        .mgmt_adr (mgmt_adr),
        .mgmt_rwn (mgmt_rwn),
        .mgmt_ack (mgmt_ack),
        .mgmt_rxe (mgmt_rxe),
        .mgmt_rxd (mgmt_rxd),
        .s_ack    (s_ack),
        .s_rxe    (s_rxe),
        .s_rxd    (s_rxd),
        .bus_err  (bus_err),
        .err_code (err_code)
`ifdef MGMT_HUB_STAT_EN
        ,
        .err_cnt  (err_cnt),
        .err_adr  (err_adr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_word(input int i, input logic [31:0] d);
        s_rxd[i*32 +: 32] = d;
    endtask

    // Drives the request during an IDLE cycle; the next cycle is WAIT_ACK c0.
    task automatic start_req(input logic rwn, input logic [31:0] adr);
        tick();
        mgmt_req = 1'b1;
        mgmt_rwn = rwn;
        mgmt_adr = adr;
    endtask

    // Waits dly cycles without ack, then drives ack in cycle c<dly> and
    // stops at that cycle's negedge.
    task automatic ack_phase(input int dly, input logic [NSLV-1:0] ack);
        for (int k = 0; k < dly; k++) begin
            tick();
            at_neg();
            chk("ack_early", 32'(mgmt_ack), 32'd0);
        end
        tick();
        s_ack = ack;
        at_neg();
    endtask

    task automatic do_read(input logic [31:0] adr, input int slv, input int adly,
                           input int rdly, input logic [31:0] dat);
        set_word(slv, dat);
        start_req(1'b1, adr);
        ack_phase(adly, NSLV'(1) << slv);
        chk("rd_ack", 32'(mgmt_ack), 32'd1);
        tick();
        s_ack    = '0;
        mgmt_req = 1'b0;
        repeat (rdly) tick();
        s_rxe = NSLV'(1) << slv;
        exp_q.push_back('{rxd: dat, err: 1'b0, code: 2'd0});
        tick();
        s_rxe = '0;
        at_neg();
        chk("rd_rxe", 32'(mgmt_rxe), 32'd1);
    endtask

    // Scoreboard: every read response the hub produces is matched to the
    // oldest expectation queued when the completing stimulus was driven.
    always @(negedge clk) begin
        exp_t e;
        if (rstn && mgmt_rxe) begin
            if (exp_q.size() == 0) begin
                chk("rxe_unexpected", 32'(mgmt_rxe), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rxd", mgmt_rxd, e.rxd);
                chk("rxe_bus_err", 32'(bus_err), 32'(e.err));
                chk("rxe_err_code", 32'(err_code), 32'(e.code));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NSLV; i++) set_word(i, 32'hA000_0000 + 32'(i));

        // Reset state
        repeat (2) tick();
        at_neg();
        chk("rst_ack", 32'(mgmt_ack), 32'd0);
        chk("rst_rxe", 32'(mgmt_rxe), 32'd0);
        chk("rst_rxd", mgmt_rxd, 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
`ifdef MGMT_HUB_STAT_EN
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_err_adr", err_adr, 32'd0);
`endif
        tick();
        rstn = 1'b1;

        // Write to slave 2, ack three cycles after the request
        start_req(1'b0, 32'h0000_0100);
        ack_phase(2, 5'b00100);
        chk("wr_ack", 32'(mgmt_ack), 32'd1);
        chk("wr_bus_err", 32'(bus_err), 32'd0);
        tick();
        mgmt_req = 1'b0;
        // Back in IDLE: a repeated ack must not be forwarded.
        at_neg();
        chk("wr_idle_next", 32'(mgmt_ack), 32'd0);
        chk("wr_idle_bus_err", 32'(bus_err), 32'd0);
        tick();
        s_ack = '0;

        // Read from slave 1: ack c2, s_rxe c5, mgmt_rxe c6
        set_word(1, 32'h1234_5678);
        start_req(1'b1, 32'h0000_0200);
        ack_phase(2, 5'b00010);
        chk("rd1_ack", 32'(mgmt_ack), 32'd1);
        tick();                                     // c3
        s_ack    = '0;
        mgmt_req = 1'b0;
        tick();                                     // c4
        tick();                                     // c5
        s_rxe = 5'b00010;
        exp_q.push_back('{rxd: 32'h1234_5678, err: 1'b0, code: 2'd0});
        at_neg();
        chk("rd1_rxe_c5", 32'(mgmt_rxe), 32'd0);
        tick();                                     // c6: first IDLE cycle
        s_rxe    = '0;
        mgmt_req = 1'b1;
        mgmt_rwn = 1'b0;
        mgmt_adr = 32'h0000_0300;
        s_ack    = 5'b00001;
        at_neg();
        chk("rd1_rxe_c6", 32'(mgmt_rxe), 32'd1);
        chk("b2b_hold", 32'(mgmt_ack), 32'd0);
        tick();                                     // c7: request accepted
        at_neg();
        chk("b2b_accept", 32'(mgmt_ack), 32'd0);
        tick();                                     // c8: WAIT_ACK
        at_neg();
        chk("b2b_ack", 32'(mgmt_ack), 32'd1);
        tick();
        mgmt_req = 1'b0;
        s_ack    = '0;

        // Stray slave pulses in IDLE
        tick();
        s_ack = '1;
        s_rxe = '1;
        at_neg();
        chk("stray_ack", 32'(mgmt_ack), 32'd0);
        tick();
        s_ack = '0;
        s_rxe = '0;
        at_neg();
        chk("stray_rxe", 32'(mgmt_rxe), 32'd0);
        chk("stray_rxd_hold", mgmt_rxd, 32'h1234_5678);
        chk("stray_bus_err", 32'(bus_err), 32'd0);

        // Read with no slave answering: ack at c63, error data at c64
        start_req(1'b1, 32'h0000_0400);
        ack_phase(63, '0);
        exp_q.push_back('{rxd: 32'hDEAD_BEEF, err: 1'b0, code: 2'd0});
        chk("tmo_ack", 32'(mgmt_ack), 32'd1);
        chk("tmo_bus_err", 32'(bus_err), 32'd1);
        chk("tmo_err_code", 32'(err_code), 32'd1);
        tick();
        mgmt_req = 1'b0;
        at_neg();
        chk("tmo_rxe_c64", 32'(mgmt_rxe), 32'd1);
        tick();

        // Read with two slaves driving rxe together
        set_word(0, 32'h0000_AAAA);
        set_word(3, 32'h0000_BBBB);
        start_req(1'b1, 32'h0000_0500);
        ack_phase(0, 5'b00001);
        chk("coll_rd_ack", 32'(mgmt_ack), 32'd1);
        chk("coll_rd_ack_err", 32'(bus_err), 32'd0);
        tick();
        s_ack    = '0;
        mgmt_req = 1'b0;
        tick();
        s_rxe = 5'b01001;
        exp_q.push_back('{rxd: 32'hDEAD_BEEF, err: 1'b1, code: 2'd3});
        at_neg();
        chk("coll_rxe_early_err", 32'(bus_err), 32'd0);
        tick();
        s_rxe = '0;
        at_neg();
        chk("coll_rxe", 32'(mgmt_rxe), 32'd1);
        tick();
        at_neg();
        chk("coll_err_pulse", 32'(bus_err), 32'd0);

        // Write with two slaves acking together
        start_req(1'b0, 32'h0000_0600);
        ack_phase(1, 5'b00011);
        chk("coll_wr_ack", 32'(mgmt_ack), 32'd1);
        chk("coll_wr_bus_err", 32'(bus_err), 32'd1);
        chk("coll_wr_code", 32'(err_code), 32'd3);
        tick();
        s_ack    = '0;
        mgmt_req = 1'b0;
        at_neg();
        chk("coll_wr_err_pulse", 32'(bus_err), 32'd0);

        // Read with two slaves acking together: error data next cycle
        start_req(1'b1, 32'h0000_0700);
        ack_phase(0, 5'b10100);
        exp_q.push_back('{rxd: 32'hDEAD_BEEF, err: 1'b0, code: 2'd0});
        chk("coll_ack_rd_ack", 32'(mgmt_ack), 32'd1);
        chk("coll_ack_rd_err", 32'(bus_err), 32'd1);
        chk("coll_ack_rd_code", 32'(err_code), 32'd3);
        tick();
        s_ack    = '0;
        mgmt_req = 1'b0;
        at_neg();
        chk("coll_ack_rd_rxe", 32'(mgmt_rxe), 32'd1);
        tick();

        // Read acked but rxe never arrives
        start_req(1'b1, 32'h0000_0800);
        ack_phase(0, 5'b00100);
        chk("rxetmo_ack", 32'(mgmt_ack), 32'd1);
        tick();                                     // r0
        s_ack    = '0;
        mgmt_req = 1'b0;
        repeat (255) tick();                        // r255
        at_neg();
        chk("rxetmo_rxe_r255", 32'(mgmt_rxe), 32'd0);
        exp_q.push_back('{rxd: 32'hDEAD_BEEF, err: 1'b1, code: 2'd2});
        tick();                                     // r256
        at_neg();
        chk("rxetmo_rxe_r256", 32'(mgmt_rxe), 32'd1);

        // Reset while waiting for read data
        start_req(1'b1, 32'h0000_0900);
        ack_phase(0, 5'b00010);
        tick();
        s_ack    = '0;
        mgmt_req = 1'b0;
        tick();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
        s_rxe = 5'b00010;
        tick();
        s_rxe = '0;
        at_neg();
        chk("rst_mid_no_rxe", 32'(mgmt_rxe), 32'd0);
        chk("rst_mid_no_ack", 32'(mgmt_ack), 32'd0);
        do_read(32'h0000_0A00, 1, 1, 2, 32'hCAFE_0001);

`ifdef MGMT_HUB_STAT_EN
        // Three ack timeouts, last one at 0xF10
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        start_req(1'b0, 32'h0000_0B00);
        ack_phase(63, '0);
        tick();
        mgmt_req = 1'b0;
        start_req(1'b0, 32'h0000_0C00);
        ack_phase(63, '0);
        tick();
        mgmt_req = 1'b0;
        start_req(1'b0, 32'h0000_0F10);
        ack_phase(63, '0);
        tick();
        mgmt_req = 1'b0;
        tick();
        at_neg();
        chk("stat_err_cnt", 32'(err_cnt), 32'd3);
        chk("stat_err_adr", err_adr, 32'h0000_0F10);
`endif

        repeat (3) tick();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
